// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter and its scoreboard.
// Round-robin arbitration is enabled by defining RF_WB_RR_EN.
package rf_wb_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam int REG_N  = 32;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_MDU  = 2;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] wa;
    logic [DATA_W-1:0] wd;
  } wb_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write counters: issue increments, accepted writeback decrements,
// and read-after-write hazard lookups for the two decode read ports.
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inc_valid,
  input  logic [REG_AW-1:0] i_inc_wa,
  input  logic              i_dec_valid,
  input  logic [REG_AW-1:0] i_dec_wa,
  input  logic [REG_AW-1:0] i_chk_ra1,
  input  logic [REG_AW-1:0] i_chk_ra2,
  output logic              o_iss_ready,
  output logic              o_hz1,
  output logic              o_hz2
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt [REG_N];
  logic             w_inc;
  logic             w_dec;
  logic             w_same;

  // Register 0 is never counted, so its entry stays at reset value forever.
  assign w_dec  = i_dec_valid && (i_dec_wa != '0);
  assign w_inc  = i_inc_valid && o_iss_ready && (i_inc_wa != '0);
  assign w_same = w_inc && w_dec && (i_inc_wa == i_dec_wa);

  assign o_iss_ready = !((i_inc_wa != '0) && (r_cnt[i_inc_wa] == CNT_MAX) &&
                         !(w_dec && (i_dec_wa == i_inc_wa)));

  assign o_hz1 = (i_chk_ra1 != '0) && (r_cnt[i_chk_ra1] != '0);
  assign o_hz2 = (i_chk_ra2 != '0) && (r_cnt[i_chk_ra2] != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_N; i++) r_cnt[i] <= '0;
    end else begin
      if (w_inc && !w_same) r_cnt[i_inc_wa] <= r_cnt[i_inc_wa] + CNT_W'(1);
      if (w_dec && !w_same) begin
        if (r_cnt[i_dec_wa] != '0) begin
          r_cnt[i_dec_wa] <= r_cnt[i_dec_wa] - CNT_W'(1);
        end else begin
`ifndef SYNTHESIS
          $display("rf_scoreboard: write to r%0d with no pending count at %0t", i_dec_wa, $time);
`endif
        end
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates NREQ writeback requesters onto the single register-file write port and
// tracks pending writes for hazard detection. Define RF_WB_RR_EN for round-robin grants.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int CNT_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*REG_AW-1:0] req_wa,
  input  logic [NREQ*DATA_W-1:0] req_wd,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   iss_valid,
  input  logic [REG_AW-1:0]      iss_wa,
  output logic                   iss_ready,
  input  logic [REG_AW-1:0]      chk_ra1,
  input  logic [REG_AW-1:0]      chk_ra2,
  output logic                   hz1,
  output logic                   hz2,
  output logic                   wb_we,
  output logic [REG_AW-1:0]      wb_wa,
  output logic [DATA_W-1:0]      wb_wd
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: a requester holds valid/wa/wd stable until it sees its ready bit;
  // a cycle with valid && ready is the transfer, and no grant is ever issued during reset.
  logic              w_found;
  logic              w_gvalid;
  logic [PTR_W-1:0]  w_gidx;
  logic [REG_AW-1:0] w_gwa;
  logic [DATA_W-1:0] w_gwd;
  logic              w_dec_valid;
  wb_t               r_wb;

`ifdef RF_WB_RR_EN
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = PTR_W'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gidx  = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (w_gvalid) begin
      r_ptr <= (w_gidx == PTR_W'(NREQ - 1)) ? '0 : w_gidx + PTR_W'(1);
    end
  end
`else
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[k]) begin
        w_found = 1'b1;
        w_gidx  = PTR_W'(k);
      end
    end
  end
`endif

  assign w_gvalid    = w_found && rst;
  assign w_gwa       = req_wa[REG_AW*int'(w_gidx) +: REG_AW];
  assign w_gwd       = req_wd[DATA_W*int'(w_gidx) +: DATA_W];
  assign w_dec_valid = w_gvalid && (w_gwa != '0);

  always_comb begin
    req_ready = '0;
    if (w_gvalid) req_ready[w_gidx] = 1'b1;
  end

  // A grant to $0 is consumed but never reaches the register file.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wb <= '0;
    end else if (w_gvalid) begin
      r_wb.we <= (w_gwa != '0);
      r_wb.wa <= w_gwa;
      r_wb.wd <= w_gwd;
    end else begin
      r_wb.we <= 1'b0;
    end
  end

  assign wb_we = r_wb.we;
  assign wb_wa = r_wb.wa;
  assign wb_wd = r_wb.wd;

  rf_scoreboard #(.CNT_W(CNT_W)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_inc_valid(iss_valid),
    .i_inc_wa   (iss_wa),
    .i_dec_valid(w_dec_valid),
    .i_dec_wa   (w_gwa),
    .i_chk_ra1  (chk_ra1),
    .i_chk_ra2  (chk_ra2),
    .o_iss_ready(iss_ready),
    .o_hz1      (hz1),
    .o_hz2      (hz2)
  );

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (WA/WD/WE) between NREQ writeback requesters: ALU writeback, load writeback and mult/div writeback.
- Tracks outstanding writes per register in a pending-count scoreboard and gives the decode stage a read-after-write hazard flag for each of its two read addresses.
- Sits between the pipeline writeback sources and the register file. Decode uses it for stall generation.

Parameters:
- NREQ, 3, number of writeback requesters. Index 0 is the highest fixed priority.
- CNT_W, 2, width of each per-register pending counter. Maximum outstanding writes per register is 2^CNT_W-1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  NREQ  per-requester write request.
- req_wa  in  NREQ*5  per-requester destination register, packed with requester i at bits [5i+4:5i].
- req_wd  in  NREQ*32  per-requester write data, packed the same way.
- req_ready  out  NREQ  one-hot grant; the request is accepted this cycle.
- iss_valid  in  1  decode issues an instruction that will write iss_wa.
- iss_wa  in  5  destination of the issued instruction.
- iss_ready  out  1  issue may be accepted (target counter not saturated).
- chk_ra1  in  5  decode read address 1.
- chk_ra2  in  5  decode read address 2.
- hz1  out  1  chk_ra1 has pending writes.
- hz2  out  1  chk_ra2 has pending writes.
- wb_we  out  1  register file WE.
- wb_wa  out  5  register file WA.
- wb_wd  out  32  register file WD.

Behaviour:
- Reset (rst=0 at posedge): all pending counters=0, wb_we=0, wb_wa=0, wb_wd=0, round-robin pointer=0. Reset mid-operation discards every in-flight grant and issue.
- Combinational outputs under reset: req_ready=0 while rst=0; hz1, hz2 and iss_ready follow the cleared state from the next cycle.
- Arbitration (combinational): req_ready[i]=1 for exactly one i, the lowest index with req_valid[i]=1. req_ready is all-zero if no request is valid.
- A requester holds valid, wa and wd stable until it sees ready.
- Grant latency: request accepted in cycle N → wb_we=1, wb_wa=req_wa[g], wb_wd=req_wd[g] registered, visible in cycle N+1.
- wb_we drops to 0 in the first cycle with no accepted grant.
- WA=0 grant: the request is accepted (ready=1) but wb_we=0 in N+1 and no counter changes. $0 is never written.
- Scoreboard increment: on iss_valid && iss_ready && iss_wa!=0, cnt[iss_wa]++. An issue to $0 is accepted and ignored.
- iss_ready=0 iff iss_wa!=0 and cnt[iss_wa] is at its maximum and no decrement of that register happens this cycle.
- Scoreboard decrement: on an accepted grant with wa!=0, cnt[wa]-- at the same posedge that loads wb_we. The hazard therefore clears in the cycle the write is presented; the register file's negedge write makes the data readable in that cycle.
- Simultaneous increment and decrement of the same register: the count is unchanged.
- A decrement with cnt=0 is a protocol error: the counter holds at 0 and does not wrap. Under simulation, emit $display with $time.
- Hazards (combinational from registered counters): hz1=(chk_ra1!=0)&&(cnt[chk_ra1]!=0); hz2 is the same for chk_ra2. Address 0 never hazards.
- Requesters with nothing granted simply wait. There is no timeout.

Optional Feature:
- Macro: RF_WB_RR_EN.
- Defined: round-robin arbitration. The search starts at the pointer. After a grant to index g, the pointer becomes (g+1) mod NREQ. With no grant, the pointer is unchanged.
- Undefined: strict fixed priority, index 0 highest; the pointer register does not exist.
- Scoreboard, latency and handshake rules are identical in both builds.

Decomposition:
- Shared package: REG_AW=5, DATA_W=32, REG_N=32, and the requester index constants REQ_ALU=0, REQ_LOAD=1, REQ_MDU=2.
- One natural sub-module, rf_scoreboard: the counter array, the inc/dec rules, iss_ready and the hz1/hz2 lookups.
- Arbitration and the wb_* output registers stay in the top module.

Test Plan:
- Reset with all counters nonzero → one cycle later: hz1=hz2=0, wb_we=0, and iss_ready=1 for every address.
- Issue $5; then ALU request wa=5, wd=0x1234 in cycle N → hz1 (chk_ra1=5) stays 1 through N, and req_ready[0]=1 in N. In N+1: wb_we=1, wb_wa=5, wb_wd=0x1234, hz1=0.
- Requesters 0 and 2 valid in the same cycle, both wa=7 with 7 issued twice:
  - Fixed priority: grant 0 then 2; hz stays 1 until the second grant's next cycle.
  - With RF_WB_RR_EN: grants alternate over 4 cycles of continuous requests.
- Three issues to $9 with CNT_W=2 → the third cycle shows iss_ready=1 then the counter is at 3. A fourth issue sees iss_ready=0, unless a $9 grant occurs in the same cycle, in which case iss_ready=1 and the count stays 3.
- Load request wa=0, wd=0xFFFFFFFF → req_ready[1]=1, next cycle wb_we=0, no counter change; issue to $0 leaves hz for chk_ra=0 at 0.
- Grant to wa=4 with cnt[4]=0 → counter stays 0, wb_we=1 still presented, error message printed.
